pipeline_hazard_ctrl: RTL

- Central sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB) of the 16-bit, 8-register, 8-bit-PC core.
- Detects load-use hazards and inserts bubbles; flushes on taken branches; selects EX operand forwarding; drains the pipe on HALT.
- Keeps saturating stall/flush counters for performance debug.
- Sits beside the decode stage; drives the pipeline-register enables and flushes, plus the PC enable and select.

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, branch flushes,
// EX operand forwarding select, HALT drain, and saturating stall/flush counters.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_Rn,
  input  logic [2:0]       id_Rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_halt,
  input  logic [2:0]       ex_Rn,
  input  logic [2:0]       ex_Rm,
  input  logic [2:0]       ex_Rd,
  input  logic             ex_w,
  input  logic             ex_load,
  input  logic             ex_branch_taken,
  input  logic [2:0]       mem_Rd,
  input  logic             mem_w,
  input  logic [2:0]       wb_Rd,
  input  logic             wb_w,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC - 1);

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             stall_inc;
  logic             flush_inc;

  // Operand 0 is EX source A (Rn), operand 1 is EX source B (Rm); MEM wins over WB.
  logic [1:0][2:0] ex_src;
  logic [1:0][1:0] fwd_sel;

  assign ex_src = {ex_Rm, ex_Rn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] = (mem_w && (mem_Rd == ex_src[gi])) ? 2'b01 :
                           (wb_w  && (wb_Rd  == ex_src[gi])) ? 2'b10 : 2'b00;
    end
  endgenerate

  assign load_use = ex_load && ex_w && id_valid &&
                    ((id_uses_rn && (id_Rn == ex_Rd)) ||
                     (id_uses_rm && (id_Rm == ex_Rd)));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    fwd_a       = fwd_sel[0];
    fwd_b       = fwd_sel[1];

    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          // The ID instruction is squashed, so its hazards and HALT don't matter.
          pc_en       = 1'b1;
          pc_sel      = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (id_valid && id_halt) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = DRAIN;
          drain_d     = DRAIN_INIT;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end
      DRAIN: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (drain_q == '0) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      HALTED: begin
        halted      = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (reset) begin
      state_d     = RUN;
      drain_d     = '0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      pc_en       = 1'b0;
      pc_sel      = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      halted      = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    drain_q     <= drain_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
